// File: rtl/linear_layer_srl_fifo_ctrl_pkg.sv
// Shared definitions for the Linear_Layer SRL stream FIFO: flag reset levels,
// output-stage load sources and a clog2 helper for parameter checks.
package linear_layer_srl_fifo_ctrl_pkg;

   localparam logic FULL_N_RESET  = 1'b1;
   localparam logic EMPTY_N_RESET = 1'b0;

   // Where the output register takes its next value from on a given edge.
   typedef enum logic [1:0] {
      LOAD_HOLD   = 2'd0,
      LOAD_SRL    = 2'd1,
      LOAD_BYPASS = 2'd2,
      LOAD_DRAIN  = 2'd3
   } load_src_e;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) result++;
      return result;
   endfunction

endpackage

// File: rtl/linear_layer_srl_fifo_ctrl_storage.sv
// Shift-register storage: newest word enters at index 0, read is an
// asynchronous mux selected by addr.
module srl_fifo_storage #(
   parameter int DATA_WIDTH = 8,
   parameter int ENTRIES    = 16,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout
);

   logic [DATA_WIDTH-1:0] mem_q [ENTRIES];

   // NOTE: storage is deliberately not reset; it maps to SRL primitives and
   // the controller never reads an entry that was not written after reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[0] <= din;
         for (int i = 1; i < ENTRIES; i++) mem_q[i] <= mem_q[i-1];
      end
   end

   always_comb begin
      dout = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (addr == ADDR_WIDTH'(i)) dout = mem_q[i];
      end
   end

endmodule

// File: rtl/linear_layer_srl_fifo_ctrl.sv
// Stream FIFO controller: occupancy, SRL write/address control and a registered
// first-word-fall-through output stage between a producer and a consumer.
module linear_layer_srl_fifo_ctrl
   import linear_layer_srl_fifo_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 17,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic                  if_full_n,
   input  logic                  if_write_ce,
   input  logic                  if_write,
   input  logic [DATA_WIDTH-1:0] if_din,
   output logic                  if_empty_n,
   input  logic                  if_read_ce,
   input  logic                  if_read,
   output logic [DATA_WIDTH-1:0] if_dout,
   output logic [ADDR_WIDTH:0]   if_num_data_valid
);

   localparam int CNT_W   = ADDR_WIDTH + 1;
   localparam int ENTRIES = DEPTH - 1;

   if (DEPTH < 2 || ADDR_WIDTH < 1 || ADDR_WIDTH < clog2(ENTRIES)) begin : g_bad_params
      $error("linear_layer_srl_fifo_ctrl: illegal DEPTH/ADDR_WIDTH combination");
   end

   logic [CNT_W-1:0]      srl_cnt_q, srl_cnt_d;
   logic                  out_valid_q, out_valid_d;
   logic                  full_n_q, full_n_d;
   logic [DATA_WIDTH-1:0] dout_q, dout_d;
   logic [ADDR_WIDTH-1:0] srl_addr;
   logic [DATA_WIDTH-1:0] srl_dout;
   logic                  push, pop, out_free, srl_we;
   load_src_e             load_src;

   assign push     = if_write & if_write_ce & full_n_q;
   assign pop      = if_read & if_read_ce & out_valid_q;
   assign out_free = ~out_valid_q | pop;
   assign srl_addr = (srl_cnt_q == '0) ? '0 : ADDR_WIDTH'(srl_cnt_q - CNT_W'(1));
   assign srl_we   = push & (load_src != LOAD_BYPASS);

   // NOTE: every combinational output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      load_src = LOAD_HOLD;
      if (out_free) begin
         if (srl_cnt_q != '0) load_src = LOAD_SRL;
         else if (push)       load_src = LOAD_BYPASS;
         else                 load_src = LOAD_DRAIN;
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      dout_d      = dout_q;
      unique case (load_src)
         LOAD_SRL: begin
            out_valid_d = 1'b1;
            dout_d      = srl_dout;
         end
         LOAD_BYPASS: begin
            out_valid_d = 1'b1;
            dout_d      = if_din;
         end
         LOAD_DRAIN: out_valid_d = 1'b0;
         default: ;
      endcase
      srl_cnt_d = srl_cnt_q + CNT_W'(srl_we) - CNT_W'(load_src == LOAD_SRL);
      full_n_d  = (srl_cnt_d != CNT_W'(ENTRIES));
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         srl_cnt_q   <= '0;
         out_valid_q <= EMPTY_N_RESET;
         full_n_q    <= FULL_N_RESET;
         dout_q      <= '0;
      end else begin
         srl_cnt_q   <= srl_cnt_d;
         out_valid_q <= out_valid_d;
         full_n_q    <= full_n_d;
         dout_q      <= dout_d;
      end
   end

   srl_fifo_storage #(
      .DATA_WIDTH (DATA_WIDTH),
      .ENTRIES    (ENTRIES),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_storage (
      .clk  (clk),
      .we   (srl_we),
      .addr (srl_addr),
      .din  (if_din),
      .dout (srl_dout)
   );

   assign if_full_n         = full_n_q;
   assign if_empty_n        = out_valid_q;
   assign if_dout           = dout_q;
   assign if_num_data_valid = srl_cnt_q + CNT_W'(out_valid_q);

endmodule

// File: tb/tb_linear_layer_srl_fifo_ctrl.sv
// Self-checking bench: randomized and directed traffic against a queue model
// of a DEPTH-word FWFT FIFO.
module tb_linear_layer_srl_fifo_ctrl;

   localparam int DATA_WIDTH = 8;
   localparam int DEPTH      = 17;
   localparam int ADDR_WIDTH = 5;

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  if_full_n, if_empty_n;
   logic                  if_write_ce, if_write, if_read_ce, if_read;
   logic [DATA_WIDTH-1:0] if_din, if_dout;
   logic [ADDR_WIDTH:0]   if_num_data_valid;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [DATA_WIDTH-1:0] model_q [$];

   always #5 clk = ~clk;

   linear_layer_srl_fifo_ctrl #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .if_full_n         (if_full_n),
      .if_write_ce       (if_write_ce),
      .if_write          (if_write),
      .if_din            (if_din),
      .if_empty_n        (if_empty_n),
      .if_read_ce        (if_read_ce),
      .if_read           (if_read),
      .if_dout           (if_dout),
      .if_num_data_valid (if_num_data_valid)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Observable flags follow directly from the model occupancy.
   task automatic check_state(input string tag);
      check({tag, ".empty_n"}, 32'(if_empty_n), 32'(model_q.size() > 0));
      check({tag, ".full_n"}, 32'(if_full_n), 32'(model_q.size() != DEPTH));
      check({tag, ".count"}, 32'(if_num_data_valid), 32'(model_q.size()));
      if (model_q.size() > 0) check({tag, ".dout"}, 32'(if_dout), 32'(model_q[0]));
      // A nonzero count with no valid output word would mean SRL data hiding behind an empty head.
      check({tag, ".invariant"}, 32'((if_num_data_valid != '0) && !if_empty_n), 32'(0));
   endtask

   // Inputs are applied 1 time unit after an edge; the model advances on the
   // next edge using pre-edge occupancy, then outputs are compared.
   task automatic drive_cycle(input string tag, input logic w, input logic [DATA_WIDTH-1:0] d,
                              input logic wce, input logic r, input logic rce);
      bit do_push, do_pop;
      if_write    = w;
      if_din      = d;
      if_write_ce = wce;
      if_read     = r;
      if_read_ce  = rce;
      do_pop  = r && rce && (model_q.size() > 0);
      do_push = w && wce && (model_q.size() < DEPTH);
      @(posedge clk);
      if (do_pop) void'(model_q.pop_front());
      if (do_push) model_q.push_back(d);
      #1;
      check_state(tag);
   endtask

   task automatic idle_cycle(input string tag);
      drive_cycle(tag, 1'b0, '0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      logic [DATA_WIDTH-1:0] d;
      logic [DATA_WIDTH-1:0] held_dout;
      logic [ADDR_WIDTH:0]   held_cnt;

      reset       = 1'b1;
      if_write    = 1'b0;
      if_write_ce = 1'b0;
      if_din      = '0;
      if_read     = 1'b0;
      if_read_ce  = 1'b0;
      #2;
      check("por.empty_n", 32'(if_empty_n), 32'(0));
      check("por.full_n", 32'(if_full_n), 32'(1));
      check("por.dout", 32'(if_dout), 32'(0));
      check("por.count", 32'(if_num_data_valid), 32'(0));
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Bypass into an empty FIFO: visible one edge later, SRL untouched.
      if_write = 1'b1; if_write_ce = 1'b1; if_din = 8'hA5;
      if_read = 1'b0;  if_read_ce = 1'b0;
      #1;
      check("bypass.srl_we", 32'(dut.srl_we), 32'(0));
      @(posedge clk);
      model_q.push_back(8'hA5);
      #1;
      check("bypass.dout", 32'(if_dout), 32'(8'hA5));
      check("bypass.count", 32'(if_num_data_valid), 32'(1));
      check_state("bypass");
      drive_cycle("bypass_rd", 1'b0, '0, 1'b0, 1'b1, 1'b1);

      // Fill to capacity, overflow attempt, then drain in order.
      for (int i = 0; i < DEPTH; i++) drive_cycle("fill", 1'b1, 8'(i), 1'b1, 1'b0, 1'b0);
      check("fill.full_n", 32'(if_full_n), 32'(0));
      drive_cycle("overflow", 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
      check("overflow.count", 32'(if_num_data_valid), 32'(DEPTH));
      for (int i = 0; i < DEPTH; i++) begin
         check("drain.order", 32'(if_dout), 32'(i));
         drive_cycle("drain", 1'b0, '0, 1'b0, 1'b1, 1'b1);
      end
      check("drain.empty_n", 32'(if_empty_n), 32'(0));
      drive_cycle("underflow", 1'b0, '0, 1'b0, 1'b1, 1'b1);

      // Steady state at 5 words with push and pop every cycle.
      for (int i = 0; i < 5; i++) drive_cycle("pre5", 1'b1, 8'($urandom), 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 50; i++) begin
         drive_cycle("stream", 1'b1, 8'($urandom), 1'b1, 1'b1, 1'b1);
         check("stream.count", 32'(if_num_data_valid), 32'(5));
      end

      // Push and pop together at full: push rejected, space next cycle.
      while (model_q.size() < DEPTH) drive_cycle("tofull", 1'b1, 8'($urandom), 1'b1, 1'b0, 1'b0);
      drive_cycle("fullpp", 1'b1, 8'h3C, 1'b1, 1'b1, 1'b1);
      check("fullpp.count", 32'(if_num_data_valid), 32'(DEPTH - 1));
      check("fullpp.full_n", 32'(if_full_n), 32'(1));
      drive_cycle("fullpp_wr", 1'b1, 8'hC3, 1'b1, 1'b0, 1'b0);
      check("fullpp_wr.count", 32'(if_num_data_valid), 32'(DEPTH));

      // Requests without clock-enable must be ignored.
      for (int i = 0; i < 4; i++) drive_cycle("drain2", 1'b0, '0, 1'b0, 1'b1, 1'b1);
      held_dout = if_dout;
      held_cnt  = if_num_data_valid;
      for (int i = 0; i < 4; i++) drive_cycle("ce_off", 1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
      check("ce_off.dout", 32'(if_dout), 32'(held_dout));
      check("ce_off.count", 32'(if_num_data_valid), 32'(held_cnt));

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         d = 8'($urandom);
         drive_cycle("rand", 1'($urandom), d, 1'($urandom_range(0, 3) != 0),
                     1'($urandom), 1'($urandom_range(0, 3) != 0));
      end

      // Asynchronous reset between edges while 9 words are held.
      while (model_q.size() > 0) drive_cycle("empty", 1'b0, '0, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 9; i++) drive_cycle("hold9", 1'b1, 8'($urandom), 1'b1, 1'b0, 1'b0);
      if_write = 1'b0; if_read = 1'b0;
      #3;
      reset = 1'b1;
      #1;
      check("arst.empty_n", 32'(if_empty_n), 32'(0));
      check("arst.full_n", 32'(if_full_n), 32'(1));
      check("arst.count", 32'(if_num_data_valid), 32'(0));
      model_q.delete();
      #1;
      reset = 1'b0;
      drive_cycle("post_rst_wr", 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
      drive_cycle("post_rst_wr2", 1'b1, 8'h6B, 1'b1, 1'b0, 1'b0);
      check("post_rst.first", 32'(if_dout), 32'(8'h5A));
      drive_cycle("post_rst_rd", 1'b0, '0, 1'b0, 1'b1, 1'b1);
      check("post_rst.second", 32'(if_dout), 32'(8'h6B));
      idle_cycle("final_idle");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
